pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage MIPS core, replacing the per-boundary hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries a payload bus, a control bus and a valid bit between two stages, and decodes the shared 5-bit stall vector for its boundary into hold or bubble actions. It adds an explicit flush, valid-gated control, and saturating hold/bubble statistics. A stuck-stall watchdog flags a boundary held for too long.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 36 +++
 rtl/pipe_stage_reg.sv | 123 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: per-boundary action encoding and stall-vector indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_t;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: decodes the shared stall vector into load/hold/bubble/flush,
// gates control on valid, and keeps hold/bubble statistics plus a stuck-stall watchdog.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 8,
    parameter int STALL_W   = 5,
    parameter int STAGE     = 2,
    parameter bit ZERO_DATA = 1'b1,
    parameter int CNT_W     = 16,
    parameter int MAX_HOLD  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STALL_W-1:0] stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  hold_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              stuck
);

    localparam int  AGE_W    = $clog2(MAX_HOLD + 1);
    // The last stage has no downstream stall bit; point at a legal index and mask it off.
    localparam int  HOLD_IDX = (STAGE < STALL_W - 1) ? STAGE + 1 : STAGE;
    localparam bit  HAS_HOLD = (STAGE < STALL_W - 1);

    stage_act_t        act;
    logic              hold_req;
    logic              valid_d, valid_q;
    logic [DATA_W-1:0] data_d,  data_q;
    logic [CTRL_W-1:0] ctrl_d,  ctrl_q;
    logic [AGE_W-1:0]  hold_age;
    logic              is_hold;
    logic              is_bubble;

    always_comb begin
        hold_req = HAS_HOLD && stall[HOLD_IDX];
        if (flush) begin
            act = ACT_FLUSH;
        end else if (hold_req) begin
            act = ACT_HOLD;
        end else if (stall[STAGE]) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_LOAD;
        end
    end

    assign is_hold   = (act == ACT_HOLD);
    assign is_bubble = (act == ACT_BUBBLE) || (act == ACT_FLUSH);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        unique case (act)
            ACT_LOAD: begin
                valid_d = in_valid;
                data_d  = in_data;
                ctrl_d  = in_valid ? in_ctrl : '0;
            end
            ACT_HOLD: ;
            ACT_BUBBLE, ACT_FLUSH: begin
                valid_d = 1'b0;
                ctrl_d  = '0;
                if (ZERO_DATA) data_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_ctrl  = ctrl_q;

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_hold),
        .clr   (clr_cnt),
        .cnt   (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_bubble),
        .clr   (clr_cnt),
        .cnt   (bubble_cnt)
    );

    // Increment is gated at MAX_HOLD so the age parks there even when MAX_HOLD < 2^AGE_W-1.
    sat_counter #(.W(AGE_W)) u_hold_age (
        .clk   (clk),
        .reset (reset),
        .inc   (is_hold && !stuck),
        .clr   (clr_cnt || !is_hold),
        .cnt   (hold_age)
    );

    assign stuck = (hold_age == AGE_W'(MAX_HOLD));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a reference model feeding an expected-result queue.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW   = 32;
    localparam int CW   = 8;
    localparam int SW   = 5;
    localparam int STG  = STG_EX;
    localparam int CNT  = 4;
    localparam int MAXH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [SW-1:0] stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          clr_cnt;
    logic [CNT-1:0] hold_cnt;
    logic [CNT-1:0] bubble_cnt;
    logic          stuck;

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .STALL_W(SW), .STAGE(STG),
        .ZERO_DATA(1'b1), .CNT_W(CNT), .MAX_HOLD(MAXH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .clr_cnt    (clr_cnt),
        .hold_cnt   (hold_cnt),
        .bubble_cnt (bubble_cnt),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           v;
        logic [DW-1:0]  d;
        logic [CW-1:0]  c;
        logic [CNT-1:0] h;
        logic [CNT-1:0] b;
        logic           s;
        string          tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic           m_v;
    logic [DW-1:0]  m_d;
    logic [CW-1:0]  m_c;
    logic [CNT-1:0] m_h;
    logic [CNT-1:0] m_b;
    int             m_age;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_d = '0; m_c = '0; m_h = '0; m_b = '0; m_age = 0;
    endtask

    task automatic check_all(input exp_t e);
        check({e.tag, ".valid"},  64'(out_valid),  64'(e.v));
        check({e.tag, ".data"},   64'(out_data),   64'(e.d));
        check({e.tag, ".ctrl"},   64'(out_ctrl),   64'(e.c));
        check({e.tag, ".hold"},   64'(hold_cnt),   64'(e.h));
        check({e.tag, ".bubble"}, 64'(bubble_cnt), 64'(e.b));
        check({e.tag, ".stuck"},  64'(stuck),      64'(e.s));
    endtask

    // Drive one cycle, predict its effect, then compare after the edge.
    task automatic step(input string tag, input logic [SW-1:0] st, input logic fl,
                        input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                        input logic clr);
        stage_act_t a;
        exp_t e;
        stall = st; flush = fl; in_valid = iv; in_data = id; in_ctrl = ic; clr_cnt = clr;
        if (fl)              a = ACT_FLUSH;
        else if (st[STG+1])  a = ACT_HOLD;
        else if (st[STG])    a = ACT_BUBBLE;
        else                 a = ACT_LOAD;
        case (a)
            ACT_LOAD: begin m_v = iv; m_d = id; m_c = iv ? ic : '0; end
            ACT_BUBBLE, ACT_FLUSH: begin m_v = 1'b0; m_d = '0; m_c = '0; end
            default: ;
        endcase
        if (clr) begin
            m_h = '0; m_b = '0;
        end else begin
            if (a == ACT_HOLD && m_h != 4'hF) m_h = m_h + 4'd1;
            if ((a == ACT_BUBBLE || a == ACT_FLUSH) && m_b != 4'hF) m_b = m_b + 4'd1;
        end
        if (clr || a != ACT_HOLD) m_age = 0;
        else if (m_age < MAXH)     m_age = m_age + 1;
        e = '{v: m_v, d: m_d, c: m_c, h: m_h, b: m_b, s: (m_age == MAXH), tag: tag};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_all(sb_q.pop_front());
    endtask

    initial begin
        exp_t z;
        reset = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; clr_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        z = '{v: 1'b0, d: '0, c: '0, h: '0, b: '0, s: 1'b0, tag: "reset"};
        check_all(z);
        reset = 1'b1;

        step("load",    5'b00000, 1'b0, 1'b1, 32'h1234, 8'h5A, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hold",  5'b01100, 1'b0, 1'b1, 32'hAAAA_0000 + 32'(i), 8'h11, 1'b0);
        step("bubble",  5'b00100, 1'b0, 1'b1, 32'hBEEF, 8'h22, 1'b0);
        step("inv_gate",5'b00000, 1'b0, 1'b0, 32'h7777, 8'hFF, 1'b0);
        step("load2",   5'b00000, 1'b0, 1'b1, 32'hCAFE_F00D, 8'h3C, 1'b0);
        step("hold2",   5'b01000, 1'b0, 1'b1, 32'h1, 8'h01, 1'b0);
        step("flush",   5'b01000, 1'b1, 1'b1, 32'h2, 8'h02, 1'b0);
        step("load3",   5'b00000, 1'b0, 1'b1, 32'h0BAD_CAFE, 8'h81, 1'b0);
        for (int i = 0; i < 20; i++)
            step("sat_hold", 5'b01000, 1'b0, 1'b1, 32'(i), 8'h44, 1'b0);
        step("clr_hold",5'b01000, 1'b0, 1'b1, 32'h5, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++)
            step("wd_hold", 5'b01000, 1'b0, 1'b1, 32'h6, 8'h66, 1'b0);
        step("wd_load", 5'b00000, 1'b0, 1'b1, 32'h1357_9BDF, 8'h99, 1'b0);
        step("bub_ff",  5'b00100, 1'b0, 1'b1, 32'h8, 8'h88, 1'b0);
        step("load4",   5'b00000, 1'b0, 1'b1, 32'hFEED_BEEF, 8'h7E, 1'b0);
        for (int i = 0; i < 4; i++)
            step("pre_rst", 5'b01000, 1'b0, 1'b1, 32'h9, 8'h09, 1'b0);

        // Asynchronous reset pulse between edges.
        #2 reset = 1'b0;
        #1;
        model_reset();
        z = '{v: 1'b0, d: '0, c: '0, h: '0, b: '0, s: 1'b0, tag: "async_rst"};
        check_all(z);
        reset = 1'b1;
        step("post_rst",5'b00000, 1'b0, 1'b1, 32'h0F0F_0F0F, 8'hC3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
